// File: rtl/jts16_cen_sched.sv
// Fractional n/m clock-enable scheduler: CH independent accumulators with
// shadowed ratio registers that commit at each channel's own cen boundary.
module jts16_cen_sched #(
  parameter int CH = 4,
  parameter int WC = 16,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_ch,
  input  logic [WC-1:0] cfg_n,
  input  logic [WC-1:0] cfg_m,
  output logic          cfg_ack,
  output logic          cfg_err,
  output logic [CH-1:0] cfg_busy,
  input  logic          pause,
  output logic [CH-1:0] cen,
  output logic [CH-1:0] cen_half
);

  logic          ch_ok;
  logic          bad_ratio;
  logic          wr_ok;
  logic          wr_bad;
  logic [CH-1:0] commit_vec;
  logic          ack_q;
  logic          err_q;

  assign ch_ok     = {{(32-CW){1'b0}}, cfg_ch} < 32'(CH);
  assign bad_ratio = (cfg_n > cfg_m) || (cfg_n == '0 && cfg_m != '0);
  assign wr_ok     = cfg_we && ch_ok && !bad_ratio;
  assign wr_bad    = cfg_we && ch_ok && bad_ratio;

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= |commit_vec;
      err_q <= wr_bad;
    end
  end

  assign cfg_ack = ack_q;
  assign cfg_err = err_q;

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic [WC-1:0] n_q, n_d, m_q, m_d;
    logic [WC-1:0] sn_q, sn_d, sm_q, sm_d;
    logic [WC:0]   acc_q, acc_d, sum;
    logic          h_q, h_d, p_q, p_d;
    logic          cen_q, cen_d, half_q, half_d;
    logic          enabled, fire, commit, wr_here;

    // acc is one bit wider than n so acc + n never wraps
    assign sum     = acc_q + {1'b0, n_q};
    assign enabled = (m_q != '0);
    assign fire    = enabled && !pause && (sum >= {1'b0, m_q});
    assign commit  = p_q && (!enabled || pause || fire);
    assign wr_here = wr_ok && (cfg_ch == CW'(gi));

    always_comb begin
      n_d    = n_q;
      m_d    = m_q;
      sn_d   = sn_q;
      sm_d   = sm_q;
      acc_d  = acc_q;
      h_d    = h_q;
      p_d    = p_q;
      cen_d  = 1'b0;
      half_d = 1'b0;
      if (enabled && !pause) begin
        if (fire) begin
          acc_d  = sum - {1'b0, m_q};
          cen_d  = 1'b1;
          half_d = h_q;
          h_d    = ~h_q;
        end else begin
          acc_d = sum;
        end
      end
      // The cen above still uses the old ratio; the new one starts from acc = 0
      if (commit) begin
        n_d   = sn_q;
        m_d   = sm_q;
        acc_d = '0;
        h_d   = 1'b0;
        p_d   = 1'b0;
      end
      // A write landing on the commit edge stays pending for the next boundary
      if (wr_here) begin
        sn_d = cfg_n;
        sm_d = cfg_m;
        p_d  = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        n_q    <= '0;
        m_q    <= '0;
        sn_q   <= '0;
        sm_q   <= '0;
        acc_q  <= '0;
        h_q    <= 1'b0;
        p_q    <= 1'b0;
        cen_q  <= 1'b0;
        half_q <= 1'b0;
      end else begin
        n_q    <= n_d;
        m_q    <= m_d;
        sn_q   <= sn_d;
        sm_q   <= sm_d;
        acc_q  <= acc_d;
        h_q    <= h_d;
        p_q    <= p_d;
        cen_q  <= cen_d;
        half_q <= half_d;
      end
    end

    assign commit_vec[gi] = commit;
    assign cfg_busy[gi]   = p_q;
    assign cen[gi]        = cen_q;
    assign cen_half[gi]   = half_q;
  end

endmodule

// File: tb/tb_jts16_cen_sched.sv
// Bench for jts16_cen_sched: pulse-count reference model (cen count = floor(k*n/m)
// over k active edges since commit) checked every cycle, plus literal scenario checks.
module tb_jts16_cen_sched;
  localparam int CH = 4;
  localparam int WC = 16;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [CW-1:0] cfg_ch = '0;
  logic [WC-1:0] cfg_n = '0;
  logic [WC-1:0] cfg_m = '0;
  logic          pause = 1'b0;
  logic          cfg_ack, cfg_err;
  logic [CH-1:0] cfg_busy, cen, cen_half;

  jts16_cen_sched #(.CH(CH), .WC(WC), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_n(cfg_n),
    .cfg_m(cfg_m), .cfg_ack(cfg_ack), .cfg_err(cfg_err), .cfg_busy(cfg_busy),
    .pause(pause), .cen(cen), .cen_half(cen_half)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per channel the ratio, pending shadow and active-edge count k
  longint        mk[CH];
  int            mn[CH], mm[CH], msn[CH], msm[CH];
  bit            mp[CH];
  logic [CH-1:0] e_cen = '0, e_half = '0, e_busy = '0;
  logic          e_ack = 1'b0, e_err = 1'b0;
  bit            m_fire;
  longint        m_q1;

  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        mk[c] = 0; mn[c] = 0; mm[c] = 0; msn[c] = 0; msm[c] = 0; mp[c] = 0;
      end
      e_cen = '0; e_half = '0; e_busy = '0; e_ack = 1'b0; e_err = 1'b0;
    end else begin
      e_ack = 1'b0;
      e_err = 1'b0;
      for (int c = 0; c < CH; c++) begin
        m_fire = 1'b0;
        m_q1   = 0;
        if (mm[c] != 0 && !pause) begin
          m_q1   = ((mk[c] + 1) * mn[c]) / mm[c];
          m_fire = m_q1 > ((mk[c] * mn[c]) / mm[c]);
          mk[c]++;
        end
        e_cen[c]  = m_fire;
        e_half[c] = m_fire && (m_q1 % 2 == 0);
        if (mp[c] && (mm[c] == 0 || pause || m_fire)) begin
          mn[c] = msn[c]; mm[c] = msm[c]; mk[c] = 0; mp[c] = 0;
          e_ack = 1'b1;
        end
      end
      if (cfg_we && cfg_ch < CH) begin
        if (cfg_n > cfg_m || (cfg_n == 0 && cfg_m != 0)) e_err = 1'b1;
        else begin
          msn[cfg_ch] = cfg_n; msm[cfg_ch] = cfg_m; mp[cfg_ch] = 1;
        end
      end
      for (int c = 0; c < CH; c++) e_busy[c] = mp[c];
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cen", 32'(cen), 32'(e_cen));
      chk("cen_half", 32'(cen_half), 32'(e_half));
      chk("cfg_busy", 32'(cfg_busy), 32'(e_busy));
      chk("cfg_ack", 32'(cfg_ack), 32'(e_ack));
      chk("cfg_err", 32'(cfg_err), 32'(e_err));
    end
  end

  // Called at a negedge; returns at the following negedge with cfg_we dropped
  task automatic wr(input int ch, input int n, input int m);
    cfg_we = 1'b1;
    cfg_ch = ch[CW-1:0];
    cfg_n  = n[WC-1:0];
    cfg_m  = m[WC-1:0];
    $display("write ch=%0d n=%0d m=%0d t=%0t", ch, n, m, $time);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  int cnt, cnt2, acks, gap_bad, last, found;
  int r, rch, rn, rm;

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_cen", 32'(cen), 0);
    chk("rst_busy", 32'(cfg_busy), 0);
    chk("rst_ack", 32'(cfg_ack), 0);
    rst = 1'b0;

    // ch0 n=1 m=4 on a disabled channel: ack two cycles after the write
    wr(0, 1, 4);
    chk("t1_busy", 32'(cfg_busy[0]), 1);
    chk("t1_ack_early", 32'(cfg_ack), 0);
    @(negedge clk);
    chk("t1_ack", 32'(cfg_ack), 1);
    cnt = 0; cnt2 = 0;
    repeat (32) begin
      @(negedge clk);
      if (cen[0] === 1'b1) cnt++;
      if (cen_half[0] === 1'b1) cnt2++;
    end
    chk("t1_cen_count", cnt, 8);
    chk("t1_half_count", cnt2, 4);

    // ch1 n=143 m=450 long-run rate and gap bounds
    wr(1, 143, 450);
    @(negedge clk);
    chk("t2_ack", 32'(cfg_ack), 1);
    cnt = 0; gap_bad = 0; last = -1;
    for (int i = 0; i < 45000; i++) begin
      @(negedge clk);
      if (cen[1] === 1'b1) begin
        if (last >= 0 && (i - last < 3 || i - last > 4)) gap_bad++;
        last = i;
        cnt++;
      end
    end
    chk("t2_count", cnt, 14300);
    chk("t2_gaps", gap_bad, 0);

    // ch2 ratio change mid-period commits on the old-rate cen
    wr(2, 1, 8);
    @(negedge clk);
    chk("t3_ack0", 32'(cfg_ack), 1);
    repeat (3) @(negedge clk);
    wr(2, 1, 2);
    chk("t3_busy", 32'(cfg_busy[2]), 1);
    acks = 0; found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (cfg_ack === 1'b1) acks++;
      if (cen[2] === 1'b1) found = 1;
      else @(negedge clk);
    end
    chk("t3_old_cen", found, 1);
    chk("t3_busy_clr", 32'(cfg_busy[2]), 0);
    chk("t3_one_ack", acks, 1);
    cnt = 0; acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (cen[2] === 1'b1) cnt++;
      if (cfg_ack === 1'b1) acks++;
    end
    chk("t3_new_period", cnt, 4);
    chk("t3_no_extra_ack", acks, 0);

    // rejected ratio and out-of-range channel
    wr(3, 5, 3);
    chk("t4_err", 32'(cfg_err), 1);
    chk("t4_busy3", 32'(cfg_busy[3]), 0);
    wr(5, 1, 2);
    chk("t4_ign_err", 32'(cfg_err), 0);
    chk("t4_ign_ack", 32'(cfg_ack), 0);
    chk("t4_ign_busy", 32'(cfg_busy), 0);

    // pause for 100 cycles with a write committed during the pause
    pause = 1'b1;
    cnt = 0;
    repeat (10) begin @(negedge clk); if (cen !== '0) cnt++; end
    wr(0, 1, 4);
    if (cen !== '0) cnt++;
    @(negedge clk);
    if (cen !== '0) cnt++;
    chk("t5_ack", 32'(cfg_ack), 1);
    repeat (88) begin @(negedge clk); if (cen !== '0) cnt++; end
    chk("t5_silent", cnt, 0);
    pause = 1'b0;
    repeat (3) begin @(negedge clk); chk("t5_quiet", 32'(cen[0]), 0); end
    @(negedge clk);
    chk("t5_first", 32'(cen[0]), 1);

    // randomized writes and pauses
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) pause = ~pause;
      if ($urandom_range(0, 7) == 0) begin
        r   = int'($urandom_range(0, 19));
        rch = int'($urandom_range(0, 3));
        rm  = int'($urandom_range(1, 40));
        rn  = int'($urandom_range(1, rm));
        if (r == 0) rch = int'($urandom_range(4, 7));
        else if (r < 3) rn = rm + int'($urandom_range(1, 5));
        else if (r == 3) begin rn = 0; rm = 0; end
        else if (r == 4) rn = 0;
        cfg_we = 1'b1;
        cfg_ch = rch[CW-1:0];
        cfg_n  = rn[WC-1:0];
        cfg_m  = rm[WC-1:0];
        $display("write ch=%0d n=%0d m=%0d pause=%0b t=%0t", rch, rn, rm, pause, $time);
      end else begin
        cfg_we = 1'b0;
      end
      @(negedge clk);
    end
    cfg_we = 1'b0;
    pause  = 1'b0;

    // reset while ch0 holds a pending write
    wr(0, 1, 1000);
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      if (cfg_busy[0] === 1'b0) found = 1;
      else @(negedge clk);
    end
    chk("t6_setup_commit", found, 1);
    repeat (2) @(negedge clk);
    wr(0, 1, 4);
    chk("t6_pending", 32'(cfg_busy[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_cen", 32'(cen), 0);
    chk("t6_busy", 32'(cfg_busy), 0);
    acks = 0; cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (cfg_ack === 1'b1) acks++;
      if (cen !== '0) cnt++;
    end
    chk("t6_no_ack", acks, 0);
    chk("t6_no_cen", cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/jts16_cen_sched.md
# jts16_cen_sched

Runtime-programmable fractional clock-enable scheduler for the S16 sound and MCU domains. It holds CH independent n/m accumulators and emits a one-cycle `cen` at rate f_clk·n/m plus a half-rate `cen_half` per channel. New ratios are written through a single configuration port (driven by the ROM-header loader or debug bus) and committed glitch-free at a channel's own cen boundary. A global `pause` freezes all channels, so board variants (S16A/S16B PCM rates, alternate MCU clocks) are selected at load time instead of by synthesis defines.

## Interface
- `CH`, 4, number of cen channels (2..8)
- `WC`, 16, width of n, m and accumulators
- `CW`, 2, width of channel index; CW ≥ log2(CH)

- `clk`  in  1  single system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cfg_we`  in  1  write strobe, one cycle per write
- `cfg_ch`  in  CW  target channel; writes with cfg_ch ≥ CH are ignored
- `cfg_n`  in  WC  numerator (increment)
- `cfg_m`  in  WC  denominator (modulus); m = 0 disables the channel
- `cfg_ack`  out  1  one-cycle pulse the cycle after any commit
- `cfg_err`  out  1  one-cycle pulse the cycle after a rejected write
- `cfg_busy`  out  CH  per-channel pending-write flag
- `pause`  in  1  freezes all accumulators; suppresses all cen outputs
- `cen`  out  CH  per-channel clock enable, one-cycle pulses
- `cen_half`  out  CH  per-channel half-rate enable, coincident with every second `cen`

## Operation
- Per channel, active registers n, m, acc (WC+1 bits, so acc+n cannot overflow), phase bit h. Shadow registers sn, sm, plus pending bit p (drives `cfg_busy`).
- Reset: n = m = acc = 0, h = 0, p = 0. Every output is 0. All channels are disabled.
- Write validation: the write is rejected (`cfg_err`, no state change) when n > m, or when n = 0 with m ≠ 0. A write with n = m is valid and gives a cen every cycle.
- Valid write: sn ← cfg_n, sm ← cfg_m, p ← 1. A second write before commit overwrites the shadow (last write wins). Only one ack is issued per commit.
- Commit moves sn/sm into n/m, clears acc, h and p, and pulses `cfg_ack` on the next cycle. A commit happens on the first edge after p = 1 where any of these holds:
  - the channel is disabled (m = 0);
  - `pause` = 1;
  - the channel produces a cen on that edge.
- When a commit coincides with a cen, the cen is still emitted using the old ratio.
- Accumulator step, enabled channel, pause = 0, each edge:
  - if acc + n ≥ m: acc ← acc + n − m, cen ← 1, cen_half ← h, h ← ~h;
  - otherwise: acc ← acc + n, cen ← 0, cen_half ← 0.
- Disabled channel: acc holds at 0, cen = cen_half = 0.
- Pause = 1: acc and h hold; cen = cen_half = 0 from the next cycle on. When pause is released, counting resumes from the held acc, with no catch-up burst.
- Simultaneous writes: only one port, so a single cfg_ch per cycle. If a write to channel k coincides with a commit of channel k, the new write stays pending (p stays 1) and commits at the following boundary.
- `cfg_ack`/`cfg_err` are OR-combined across channels. At most one write per cycle means at most one err per cycle. Acks from several channels can coincide; a single pulse is then sufficient.

## Timing
- All outputs are registered. Output latency from the deciding edge is 0: the cen is high for exactly the cycle after the edge where acc + n ≥ m.
- After a commit at edge E0 (acc = 0), the first cen is high after edge Ek, where k = ceil(m/n). With n = 1, m = 4: cen after E4, E8, E12 and so on.
- Long-run rate: exactly n pulses per m clocks, with no drift.
- Disabled-channel write: commit happens on the edge after the `cfg_we` edge; `cfg_ack` is high the cycle after that. Total latency from `cfg_we` high to `cfg_ack` high is 2 cycles.
- Enabled-channel write: commit waits for the next cen, at most ceil(m_old/n_old) cycles. `cfg_busy[k]` stays high until the commit edge.
- `rst` asserted mid-operation clears everything on the next edge, including pending writes; no ack is issued for dropped writes.

## Test plan
- Reset, then write ch0 n=1 m=4 → `cfg_ack` 2 cycles after the write; `cen[0]` every 4th cycle; `cen_half[0]` every 8th cycle, on the second cen.
- ch1 n=143 m=450, run 450000 cycles → exactly 143000 `cen[1]` pulses; the gap between pulses is always 3 or 4 cycles.
- ch2 running n=1 m=8; write n=1 m=2 mid-period → `cfg_busy[2]` high until the next old-rate cen; that cen is emitted; new period 2 follows; one `cfg_ack`.
- Write n=5 m=3 to ch3 → `cfg_err` pulse, `cfg_busy[3]` stays 0, ch3 outputs unchanged; cfg_ch=5 with CH=4 → ignored, no ack or err.
- `pause` high for 100 cycles mid-period on ch0 n=1 m=4 → no cen during pause; a write issued during pause commits and acks in 2 cycles; after release, the first cen comes 4 cycles later.
- `rst` pulse while ch0 has a pending write → all `cen`, `cfg_busy` and acc cleared; no `cfg_ack` follows.
